// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus-buffer write port among NUM_REQ valid/ready producers.
// Optional stall timeout with forced grant release is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 24,
    parameter int TO_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       RSTn,
    input  logic [NUM_REQ*DATA_W-1:0]  REQ_DATA,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         arb_ready,
    output logic [DATA_W-1:0]          TOP_DATA,
    output logic                       top_valid,
    input  logic                       bus_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_last_nxt;

    logic [IDX_W-1:0]   w_pick;
    logic               w_pick_vld;
    logic               w_gnt_valid;
    logic [DATA_W-1:0]  w_gnt_data;
    logic               w_accept;
    logic               w_stall;
    logic               w_timeout;

    assign w_gnt_valid = req_valid[r_grant];
    assign w_gnt_data  = REQ_DATA[int'(r_grant)*DATA_W +: DATA_W];

    // Scan last+1, last+2, ... mod NUM_REQ; iterating from the far end lets the
    // nearest valid index overwrite the others, so no early exit is needed.
    always_comb begin
        automatic int idx;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                w_pick     = IDX_W'(idx);
                w_pick_vld = 1'b1;
            end
        end
    end

    // Datapath outputs are purely combinational off the registered grant.
    always_comb begin
        top_valid = (r_state == S_LOCK) && w_gnt_valid;
        TOP_DATA  = top_valid ? w_gnt_data : '0;
        busy      = (r_state == S_LOCK);
        grant_id  = r_grant;
        arb_ready = '0;
        if (top_valid && bus_ready) begin
            arb_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
        end
    end

    assign w_accept = top_valid && bus_ready;
    assign w_stall  = top_valid && !bus_ready;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] r_stall_cnt;
    logic        r_timeout_err;

    // The stall cycle that would bring the count up to TO_CYCLES triggers release.
    assign w_timeout   = w_stall && (r_stall_cnt == 16'(TO_CYCLES - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_stall && !w_timeout) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = S_LOCK;
                end
            end
            S_LOCK: begin
                if (w_accept) begin
                    w_last_nxt  = r_grant;
                    w_state_nxt = S_IDLE;
                end else if (!w_gnt_valid) begin
                    // Requester withdrew without a handshake: it keeps its place in the rotation.
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    w_last_nxt  = r_grant;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!RSTn) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: drivers queue expected accepts, a negedge monitor checks them.
// Directed scenarios cover single grant, rotation, stall, async reset, valid drop and timeout.
module tb_bus_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 24;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int STALL_N = 5;
`else
    localparam int STALL_N = 10;
`endif

    typedef struct {
        logic [1:0]        id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      RSTn;
    logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        arb_ready;
    logic [DATA_W-1:0]         TOP_DATA;
    logic                      top_valid;
    logic                      bus_ready;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      timeout_err;

    logic [DATA_W-1:0] dat [NUM_REQ] = '{24'h0A0B0C, 24'hA5A5A5, 24'hC3C3C3, 24'h5A1234};

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    bus_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TO_CYCLES(8)) dut (
        .clk         (clk),
        .RSTn        (RSTn),
        .REQ_DATA    (REQ_DATA),
        .req_valid   (req_valid),
        .arb_ready   (arb_ready),
        .TOP_DATA    (TOP_DATA),
        .top_valid   (top_valid),
        .bus_ready   (bus_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.data = dat[id];
        exp_q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_top_valid"}, 32'(top_valid), 0);
        check({tag, "_top_data"},  32'(TOP_DATA), 0);
        check({tag, "_arb_ready"}, 32'(arb_ready), 0);
        check({tag, "_busy"},      32'(busy), 0);
        check({tag, "_timeout"},   32'(timeout_err), 0);
    endtask

    // Monitor: every accepted word must match the head of the expectation queue.
    always @(negedge clk) begin
        if (arb_ready != '0) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: arb_ready=%b with nothing expected at %0t", arb_ready, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_id",    32'(grant_id), 32'(mon_e.id));
                check("sb_data",  32'(TOP_DATA), 32'(mon_e.data));
                check("sb_ready", 32'(arb_ready), 32'(4'b0001 << mon_e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        RSTn      = 1'b0;
        req_valid = '0;
        bus_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) REQ_DATA[i*DATA_W +: DATA_W] = dat[i];
        #3;
        check_idle_outputs("rst");
        check("rst_grant_id", 32'(grant_id), 0);
        repeat (2) tick();
        RSTn = 1'b1;

        // Single requester 1 with bus ready
        tick();
        req_valid = 4'b0010;
        bus_ready = 1'b1;
        push(1);
        tick();
        @(negedge clk);
        check("t1_top_valid", 32'(top_valid), 1);
        check("t1_busy",      32'(busy), 1);
        tick();
        req_valid = '0;
        @(negedge clk);
        check_idle_outputs("t1_after");
        check("t1_grant_kept", 32'(grant_id), 1);

        // Full rotation from reset: 0,1,2,3,0, one accept every other cycle
        tick();
        RSTn = 1'b0;
        tick();
        RSTn      = 1'b1;
        req_valid = 4'b1111;
        bus_ready = 1'b1;
        push(0); push(1); push(2); push(3); push(0);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("t2_pulse", 32'(|arb_ready), 32'((i % 2) == 0));
        end
        req_valid = '0;

        // Requester 2 stalled, then accepted
        tick();
        req_valid = 4'b0100;
        bus_ready = 1'b0;
        tick();
        for (int i = 0; i < STALL_N; i++) begin
            @(negedge clk);
            check("t3_top_valid", 32'(top_valid), 1);
            check("t3_top_data",  32'(TOP_DATA), 32'h00C3C3C3);
            check("t3_grant_id",  32'(grant_id), 2);
            check("t3_arb_ready", 32'(arb_ready), 0);
            tick();
        end
        bus_ready = 1'b1;
        push(2);
        tick();
        req_valid = '0;

        // Asynchronous reset during LOCK on requester 3
        tick();
        req_valid = 4'b1000;
        bus_ready = 1'b0;
        tick();
        @(negedge clk);
        check("t4_busy",     32'(busy), 1);
        check("t4_grant_id", 32'(grant_id), 3);
        #2;
        RSTn = 1'b0;
        #1;
        check_idle_outputs("t4_rst");
        check("t4_rst_grant_id", 32'(grant_id), 0);
        req_valid = 4'b1111;
        bus_ready = 1'b1;
        push(0);
        tick();
        RSTn = 1'b1;
        tick();
        @(negedge clk);
        check("t4_first_grant", 32'(grant_id), 0);
        tick();
        req_valid = '0;

        // Requester 1 drops valid while locked; requester 3 then wins
        tick();
        req_valid = 4'b1010;
        bus_ready = 1'b0;
        tick();
        @(negedge clk);
        check("t5_grant_id", 32'(grant_id), 1);
        tick();
        req_valid = 4'b1000;
        bus_ready = 1'b1;
        push(3);
        @(negedge clk);
        check("t5_drop_top_valid", 32'(top_valid), 0);
        check("t5_drop_arb_ready", 32'(arb_ready), 0);
        tick();
        @(negedge clk);
        check("t5_idle_busy", 32'(busy), 0);
        tick();
        tick();
        req_valid = '0;

`ifdef BUS_ARB_TIMEOUT_EN
        // Forced release after 8 stall cycles; requester 1 is next
        tick();
        req_valid = 4'b0011;
        bus_ready = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0) bad++;
            tick();
        end
        check("t6_stall_window", 32'(bad), 0);
        bus_ready = 1'b1;
        push(1);
        @(negedge clk);
        check("t6_timeout_err", 32'(timeout_err), 1);
        check("t6_busy",        32'(busy), 0);
        tick();
        @(negedge clk);
        check("t6_timeout_clr", 32'(timeout_err), 0);
        check("t6_next_grant",  32'(grant_id), 1);
        tick();
        req_valid = 4'b0001;
        push(0);
        tick();
        tick();
        req_valid = '0;
`else
        // No timeout built: LOCK on requester 0 holds for 110 stall cycles
        tick();
        req_valid = 4'b0011;
        bus_ready = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (timeout_err !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0 || top_valid !== 1'b1) bad++;
            tick();
        end
        check("t6_lock_hold", 32'(bad), 0);
        bus_ready = 1'b1;
        push(0);
        push(1);
        tick();
        req_valid = 4'b0010;
        tick();
        @(negedge clk);
        check("t6_next_grant", 32'(grant_id), 1);
        tick();
        req_valid = '0;
`endif

        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
